// File: rtl/mux_writedata_pipe.sv
// rtl/mux_writedata_pipe.sv - write-data source mux feeding a two-entry skid FIFO
// Register-0 transfers can be dropped; out-of-range selectors raise a sticky flag.
module mux_writedata_pipe #(
  parameter int WIDTH     = 32,
  parameter int N_SRC     = 6,
  parameter int SEL_W     = 3,
  parameter int ADDR_W    = 5,
  parameter int ZERO_DROP = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       selector,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       data_out,
  output logic [ADDR_W-1:0]      addr_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             count,
  output logic                   sel_err
);

  logic [1:0]        cnt, cnt_nxt;
  logic [WIDTH-1:0]  head_data, head_data_nxt, skid_data, skid_data_nxt, sel_word;
  logic [ADDR_W-1:0] head_addr, head_addr_nxt, skid_addr, skid_addr_nxt;
  logic              in_ready_r, sel_err_r;
  logic              accept, pop, store, sel_oob;

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (selector == SEL_W'(k)) sel_word = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign sel_oob = 32'(selector) >= 32'(N_SRC);
  assign accept  = in_valid && in_ready_r;
  assign pop     = (cnt != 2'd0) && out_ready;
  // A dropped register-0 write still completes its handshake.
  assign store   = accept && !((ZERO_DROP != 0) && (addr_in == '0));

  always_comb begin
    cnt_nxt       = cnt;
    head_data_nxt = head_data;
    head_addr_nxt = head_addr;
    skid_data_nxt = skid_data;
    skid_addr_nxt = skid_addr;
    if (flush) begin
      cnt_nxt = 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (store) begin
            cnt_nxt       = 2'd1;
            head_data_nxt = sel_word;
            head_addr_nxt = addr_in;
          end
        end
        2'd1: begin
          if (store && pop) begin
            head_data_nxt = sel_word;
            head_addr_nxt = addr_in;
          end else if (store) begin
            cnt_nxt       = 2'd2;
            skid_data_nxt = sel_word;
            skid_addr_nxt = addr_in;
          end else if (pop) begin
            cnt_nxt = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            cnt_nxt       = 2'd1;
            head_data_nxt = skid_data;
            head_addr_nxt = skid_addr;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 2'd0;
      head_data  <= '0;
      head_addr  <= '0;
      skid_data  <= '0;
      skid_addr  <= '0;
      in_ready_r <= 1'b0;
      sel_err_r  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      head_data  <= head_data_nxt;
      head_addr  <= head_addr_nxt;
      skid_data  <= skid_data_nxt;
      skid_addr  <= skid_addr_nxt;
      in_ready_r <= (cnt_nxt != 2'd2);
      if (accept && sel_oob) sel_err_r <= 1'b1;
    end
  end

  assign count     = cnt;
  assign out_valid = (cnt != 2'd0);
  assign in_ready  = in_ready_r;
  assign sel_err   = sel_err_r;
  assign data_out  = out_valid ? head_data : '0;
  assign addr_out  = out_valid ? head_addr : '0;

endmodule

// File: tb/tb_mux_writedata_pipe.sv
// tb/tb_mux_writedata_pipe.sv - randomized and directed bench for mux_writedata_pipe
// A queue-based model tracks stored entries, readiness and the sticky selector error.
module tb_mux_writedata_pipe;
  localparam int WIDTH = 32, N_SRC = 6, SEL_W = 3, ADDR_W = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [SEL_W-1:0]       selector;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic [ADDR_W-1:0]      addr_in;
  logic                   in_valid, in_ready, flush;
  logic [WIDTH-1:0]       data_out;
  logic [ADDR_W-1:0]      addr_out;
  logic                   out_valid, out_ready, sel_err;
  logic [1:0]             count;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+WIDTH-1:0] mq[$];
  logic m_in_ready, m_sel_err;
  logic [41:0] dut_vec;

  mux_writedata_pipe #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .ZERO_DROP(1)) dut (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .data_out(data_out),
    .addr_out(addr_out), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  assign dut_vec = {count, out_valid, in_ready, sel_err, addr_out, data_out};

  function automatic logic [41:0] exp_vec();
    logic [ADDR_W+WIDTH-1:0] h;
    h = (mq.size() > 0) ? mq[0] : '0;
    return {2'(mq.size()), mq.size() > 0, m_in_ready, m_sel_err, h};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in_ready = 1'b0;
    m_sel_err  = 1'b0;
  endtask

  // Advance one clock; inputs are held from the preceding negedge.
  task automatic cycle();
    logic acc, pop;
    logic [WIDTH-1:0] w;
    acc = in_valid && m_in_ready;
    pop = (mq.size() > 0) && out_ready;
    w = (int'(selector) < N_SRC) ? data_in[int'(selector)*WIDTH +: WIDTH] : '0;
    @(posedge clk);
    if (acc && int'(selector) >= N_SRC) m_sel_err = 1'b1;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc && addr_in != '0) mq.push_back({addr_in, w});
    end
    m_in_ready = (mq.size() != 2);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; selector = 0; addr_in = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle_inputs(); data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 42'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 42'd0);
    end
    reset = 1;
    cycle();
    checks++;
    if (in_ready !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    selector = 2; data_in[2*WIDTH +: WIDTH] = 32'hCAFE0002; addr_in = 7;
    in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'hCAFE0002 || addr_out !== 5'd7 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL basic_head got=%h exp=%h", dut_vec, exp_vec());
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || data_out !== '0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL basic_drain got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals[3];
    logic [WIDTH-1:0] got[$];
    int idx = 0;
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
    selector = 0; out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      data_in[0 +: WIDTH] = vals[i]; addr_in = 5'(i + 1);
      cycle();
      if (i < 2) idx++;
    end
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || data_out !== vals[0] || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL b2b_full got=%h exp=%h", dut_vec, exp_vec());
    end
    out_ready = 1;
    for (int c = 0; c < 10 && (out_valid || in_valid); c++) begin
      if (out_valid) got.push_back(data_out);
      if (in_valid && in_ready) begin
        cycle(); in_valid = 0;
      end else cycle();
    end
    checks++;
    if (got.size() != 3 || got[0] !== vals[0] || got[1] !== vals[1] || got[2] !== vals[2]) begin
      errors++; $display("FAIL b2b_order got_n=%0d first=%h exp_n=3 first=%h", got.size(),
                         (got.size() > 0) ? got[0] : '0, vals[0]);
    end
    checks++;
    if (dut_vec !== exp_vec() || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty got=%h exp=%h", dut_vec, exp_vec());
    end
    out_ready = 0;
  endtask

  task automatic test_sel_err();
    selector = 7; addr_in = 3; data_in = {N_SRC{32'hFFFF_FFFF}}; in_valid = 1; out_ready = 1;
    cycle();
    checks++;
    if (data_out !== 32'h0 || out_valid !== 1'b1 || sel_err !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL sel_oob got=%h exp=%h", dut_vec, exp_vec());
    end
    selector = 1;
    repeat (3) cycle();
    in_valid = 0;
    cycle();
    checks++;
    if (sel_err !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL sel_sticky got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_zero_drop();
    addr_in = 0; selector = 1; in_valid = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (in_ready !== 1'b1 || count !== 2'd0 || out_valid !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL zero_drop[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    in_valid = 0;
  endtask

  task automatic test_flush();
    selector = 0; addr_in = 9; in_valid = 1; out_ready = 0;
    repeat (2) cycle();
    checks++;
    if (count !== 2'd2 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL flush_fill got=%h exp=%h", dut_vec, exp_vec());
    end
    flush = 1; out_ready = 1;
    cycle();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL flush_clear got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_SRC; k++) data_in[k*WIDTH +: WIDTH] = $urandom;
      selector  = SEL_W'($urandom_range(7, 0));
      addr_in   = ($urandom_range(7, 0) == 0) ? '0 : ADDR_W'($urandom);
      in_valid  = $urandom_range(1, 0);
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(19, 0) == 0);
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    selector = 0; addr_in = 4; in_valid = 1; out_ready = 0;
    repeat (2) cycle();
    in_valid = 0;
    checks++;
    if (count !== 2'd2 || sel_err !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL async_pre got=%h exp=%h", dut_vec, exp_vec());
    end
    #2 reset = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 42'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", dut_vec, 42'd0);
    end
    @(negedge clk);
    reset = 1;
    cycle();
    checks++;
    if (dut_vec !== exp_vec() || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_release got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sel_err();
    test_zero_drop();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
